token_drain: RTL
================

// Module: token_drain
// PURPOSE
//  Downstream stage for single-cycle token pulse streams (e.g. the b output of the token doubler).
//  Counts incoming pulses in a saturating pending counter.
//  Drains them one per transfer over a valid/ready interface.
//  Rate-shapes output: at most BURST tokens back-to-back, then GAP forced idle cycles. Sticky overflow on drop.
// PARAMETERS
//  CNT_W  4  pending-counter width; capacity = 2**CNT_W-1 tokens (CNT_W >= 2)
//  BURST  4  max consecutive transfers before a gap (BURST >= 1)
//  GAP    2  forced idle cycles after each full burst; 0 = no shaping (GAP >= 0)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      reset, asynchronous, active-low
//  clr        in   1      synchronous clear: count, state, overflow
//  tok_in     in   1      token pulse; each high cycle = one token
//  out_valid  out  1      token available to consumer
//  out_ready  in   1      consumer accepts; transfer when out_valid & out_ready
//  level      out  CNT_W  pending token count (registered)
//  overflow   out  1      sticky: a token was dropped
//  drop_cnt   out  16     only with TOKEN_DRAIN_STATS_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=0, async):
//    - out_valid=0, level=0, overflow=0, drop_cnt=0
//    - state=IDLE; burst and gap counters = 0
//  - inc = tok_in & (level != max | xfer); dec = xfer = out_valid & out_ready.
//  - level_next = level + inc - dec. Simultaneous inc and dec: level unchanged.
//  - Drop: tok_in & level==max & ~xfer. Token is lost; overflow<=1 next edge.
//  - level==max with tok_in and xfer in same cycle: token accepted, no overflow.
//  - out_valid = (state==SEND); a function of registered state only.
//  - Consumer may tie out_ready high; no comb path from out_ready to out_valid.
//  - FSM states IDLE / SEND / GAP:
//    - IDLE->SEND when level_next != 0. Latency: tok_in at edge k, empty -> out_valid from edge k.
//    - SEND, on xfer:
//      - bcnt++.
//      - If bcnt==BURST-1 and GAP>0 -> GAP, with gcnt=0 and bcnt=0.
//      - Else if level_next==0 -> IDLE, with bcnt=0.
//    - SEND without xfer: hold. Once asserted, out_valid stays high until a transfer.
//    - GAP: gcnt++ each cycle; after GAP cycles -> SEND if level_next!=0, else IDLE.
//    - GAP=0: gap path never taken; bcnt ignored.
//    - Tokens keep accumulating during GAP and IDLE.
//  - Burst count restarts after IDLE or GAP; a partial burst followed by IDLE is not carried over.
//  - clr=1:
//    - next edge: level=0, overflow=0, state=IDLE, counters=0; out_valid=0 from that edge.
//    - clr dominates tok_in and xfer in the same cycle; the token and the transfer are discarded.
//  - rst asserted mid-burst: outputs reset immediately (async). Pending tokens are lost.
// CONFIGURATION
//  TOKEN_DRAIN_STATS_EN defined:
//    - drop_cnt port present: saturating count of dropped tokens (holds at 16'hFFFF).
//    - Cleared by rst or clr.
//  TOKEN_DRAIN_STATS_EN undefined:
//    - drop_cnt port and its logic absent.
//    - All other behaviour identical.
// TESTING (CNT_W=4, BURST=4, GAP=2 unless stated)
//  1 Reset:
//    - Stimulus: rst low mid-operation, level=7.
//    - Response: out_valid=0, level=0, overflow=0 immediately, before next clk.
//  2 Single token, out_ready=1:
//    - Stimulus: tok_in for 1 cycle.
//    - Response: out_valid high exactly 1 cycle; level 1 then 0; back to IDLE.
//  3 Shaping, out_ready=1:
//    - Stimulus: 10 back-to-back tokens.
//    - Response: out_valid pattern 4 on, 2 off, 4 on, 2 off, 2 on; 10 transfers total.
//  4 Overflow, out_ready=0:
//    - Stimulus: 20 tokens.
//    - Response: level=15; overflow=1 after 16th; drop_cnt=5 (stats build).
//    - Then out_ready=1: exactly 15 transfers, overflow stays 1.
//  5 Boundary:
//    - Stimulus: level=15, tok_in=1 and out_ready=1 same cycle.
//    - Response: level stays 15, overflow stays 0.
//    - Stimulus: clr mid-burst.
//    - Response: level=0, out_valid=0, overflow=0 next cycle.
//  6 Conservation, random out_ready (50%):
//    - Stimulus: 100 cycles tok_in at 30%, then 200 idle cycles.
//    - Response: transfers == tokens accepted; level=0; overflow=0.

Source files
------------

// File: rtl/token_drain.sv
// token_drain: counts token pulses and drains them over valid/ready with burst/gap rate shaping.
// Optional drop statistics under TOKEN_DRAIN_STATS_EN. Rev 1.0
`default_nettype none

module token_drain #(
  parameter int CNT_W = 4,
  parameter int BURST = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             tok_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] level,
  output logic             overflow
`ifdef TOKEN_DRAIN_STATS_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  localparam int BCW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0] LVL_MAX = {CNT_W{1'b1}};
  localparam logic [BCW-1:0]   B_LAST  = BCW'(BURST - 1);
  localparam logic [GCW-1:0]   G_LAST  = GCW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [BCW-1:0]   bcnt, bcnt_n;
  logic [GCW-1:0]   gcnt, gcnt_n;
  logic             xfer, inc, drop;
  logic [CNT_W-1:0] level_next;

  // out_valid comes from registered state only, so out_ready may be tied high
  assign out_valid = (state == ST_SEND);

  always_comb begin
    xfer       = out_valid & out_ready;
    inc        = tok_in & ((level != LVL_MAX) | xfer);
    drop       = tok_in & (level == LVL_MAX) & ~xfer;
    level_next = level + CNT_W'(inc) - CNT_W'(xfer);
    state_n    = state;
    bcnt_n     = bcnt;
    gcnt_n     = gcnt;
    case (state)
      ST_IDLE: begin
        if (level_next != '0) state_n = ST_SEND;
      end
      ST_SEND: begin
        if (xfer) begin
          if ((GAP > 0) && (bcnt == B_LAST)) begin
            state_n = ST_GAP;
            bcnt_n  = '0;
            gcnt_n  = '0;
          end else if (level_next == '0) begin
            state_n = ST_IDLE;
            bcnt_n  = '0;
          end else begin
            bcnt_n  = (GAP > 0) ? bcnt + 1'b1 : '0;
          end
        end
      end
      ST_GAP: begin
        if (gcnt == G_LAST) begin
          gcnt_n  = '0;
          state_n = (level_next != '0) ? ST_SEND : ST_IDLE;
        end else begin
          gcnt_n  = gcnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        bcnt_n  = '0;
        gcnt_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      bcnt     <= '0;
      gcnt     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      state    <= ST_IDLE;
      bcnt     <= '0;
      gcnt     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      bcnt     <= bcnt_n;
      gcnt     <= gcnt_n;
      level    <= level_next;
      overflow <= overflow | drop;
    end
  end

`ifdef TOKEN_DRAIN_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (clr) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire
